// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the I/D-cache memory port arbiter:
//               FSM state encoding, arb_owner codes and the last-served tag
//               used by the round-robin tie-break (ARB_RR_EN builds only).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // State values equal the owner codes so arb_owner is a straight copy.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_I = 2'b01,
    ST_GRANT_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_e;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the I-cache, D-cache and memory handshake signals of
//               the memory port arbiter.
//               slave  : arbiter view (serves cache requests, drives memory)
//               master : environment view (caches + memory model)
//   I-cache : i_req_valid, i_req_addr -> i_req_ready, i_req_data
//   D-cache : d_req_valid, d_req_wr, d_req_addr, d_wr_data
//             -> d_req_ready, d_req_data
//   Memory  : mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data
//             <- mem_req_ready, mem_req_data
//   Status  : arb_owner (00 none, 01 I, 10 D)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic [DATA_W-1:0] i_req_data;

  logic              d_req_valid;
  logic              d_req_wr;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_req_ready;
  logic [DATA_W-1:0] d_req_data;

  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_req_data;

  logic [1:0]        arb_owner;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_req_data,
    input  d_req_valid, d_req_wr, d_req_addr, d_wr_data,
    output d_req_ready, d_req_data,
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    input  mem_req_ready, mem_req_data,
    output arb_owner
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_req_data,
    output d_req_valid, d_req_wr, d_req_addr, d_wr_data,
    input  d_req_ready, d_req_data,
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    output mem_req_ready, mem_req_data,
    input  arb_owner
  );
endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational round-robin picker. A lone requester always
//               wins; on a tie the requester that was not served last wins.
//   i_valid, d_valid : request lines
//   last_served      : requester granted most recently
//   grant_i, grant_d : one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  wire logic  i_valid,
  input  wire logic  d_valid,
  input  wire last_e last_served,
  output logic       grant_i,
  output logic       grant_d
);
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_valid && d_valid) begin
      grant_i = (last_served == LAST_D);
      grant_d = (last_served == LAST_I);
    end else begin
      grant_i = i_valid;
      grant_d = d_valid;
    end
  end
endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory request port between the I-cache (reads)
//               and the D-cache (reads and write-backs), one transaction in
//               flight. The winner's request is registered toward memory;
//               memory ready/data are routed combinationally to the owner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (cache + memory handshakes)
// Config      : ARB_RR_EN defined   -> round-robin tie-break
//               ARB_RR_EN undefined -> fixed priority, D-cache wins ties
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic grant_i;
  logic grant_d;

`ifdef ARB_RR_EN
  last_e last_served_q, last_served_d;

  arb_rr_pick u_rr_pick (
    .i_valid     (bus.i_req_valid),
    .d_valid     (bus.d_req_valid),
    .last_served (last_served_q),
    .grant_i     (grant_i),
    .grant_d     (grant_d)
  );

  // Only a grant taken from IDLE moves the round-robin pointer.
  always_comb begin
    last_served_d = last_served_q;
    if (state_q == ST_IDLE) begin
      if (grant_d)      last_served_d = LAST_D;
      else if (grant_i) last_served_d = LAST_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_served_q <= LAST_I;
    else     last_served_q <= last_served_d;
  end
`else
  assign grant_d = bus.d_req_valid;
  assign grant_i = bus.i_req_valid & ~bus.d_req_valid;
`endif

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // mem_req_ready is deliberately ignored here.
        if (grant_d) begin
          state_d     = ST_GRANT_D;
          mem_valid_d = 1'b1;
          mem_wr_d    = bus.d_req_wr;
          mem_addr_d  = bus.d_req_addr;
          mem_wdata_d = bus.d_wr_data;
        end else if (grant_i) begin
          state_d     = ST_GRANT_I;
          mem_valid_d = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = bus.i_req_addr;
          mem_wdata_d = '0;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        // Requester inputs are ignored; latched values held until done.
        if (bus.mem_req_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A reset cycle suppresses completion even if memory answers in it.
  logic i_done;
  logic d_done;
  assign i_done = (state_q == ST_GRANT_I) && bus.mem_req_ready && !rst;
  assign d_done = (state_q == ST_GRANT_D) && bus.mem_req_ready && !rst;

  assign bus.i_req_ready   = i_done;
  assign bus.i_req_data    = i_done ? bus.mem_req_data : '0;
  assign bus.d_req_ready   = d_done;
  assign bus.d_req_data    = d_done ? bus.mem_req_data : '0;

  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_wr    = mem_wr_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_wr_data   = mem_wdata_q;

  always_comb begin
    bus.arb_owner = OWN_NONE;
    if (state_q == ST_GRANT_I)      bus.arb_owner = OWN_I;
    else if (state_q == ST_GRANT_D) bus.arb_owner = OWN_D;
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               reference model is compared with the DUT every cycle, and
//               directed scenarios pin literal expectations.
//               Build with +define+ARB_RR_EN for the round-robin variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner: 0 none, 1 I-cache, 2 D-cache. One in-flight transaction record.
  int          m_owner   = 0;
  bit          m_wr      = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  int          m_last    = 1;   // requester served most recently (1 = I)

  task automatic model_compare();
    bit          exp_i_rdy;
    bit          exp_d_rdy;
    exp_i_rdy = !rst && (m_owner == 1) && bus.mem_req_ready;
    exp_d_rdy = !rst && (m_owner == 2) && bus.mem_req_ready;
    chk("m_owner", {30'd0, bus.arb_owner}, m_owner);
    chk("m_valid", {31'd0, bus.mem_req_valid}, (m_owner != 0));
    if (m_owner != 0) begin
      chk("m_wr",   {31'd0, bus.mem_req_wr}, m_wr);
      chk("m_addr", bus.mem_req_addr, m_addr);
      if (m_wr) chk("m_wdata", bus.mem_wr_data, m_wdata);
    end
    chk("m_i_rdy",  {31'd0, bus.i_req_ready}, exp_i_rdy);
    chk("m_d_rdy",  {31'd0, bus.d_req_ready}, exp_d_rdy);
    chk("m_i_data", bus.i_req_data, exp_i_rdy ? bus.mem_req_data : 32'd0);
    chk("m_d_data", bus.d_req_data, exp_d_rdy ? bus.mem_req_data : 32'd0);
  endtask

  task automatic model_advance();
    int winner;
    if (rst) begin
      m_owner = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_last = 1;
    end else if (m_owner == 0) begin
      winner = 0;
      if (bus.i_req_valid && bus.d_req_valid) begin
`ifdef ARB_RR_EN
        winner = (m_last == 1) ? 2 : 1;
`else
        winner = 2;
`endif
      end else if (bus.d_req_valid) winner = 2;
      else if (bus.i_req_valid)     winner = 1;
      if (winner == 2) begin
        m_owner = 2; m_wr = bus.d_req_wr; m_addr = bus.d_req_addr; m_wdata = bus.d_wr_data;
        m_last = 2;
      end else if (winner == 1) begin
        m_owner = 1; m_wr = 1'b0; m_addr = bus.i_req_addr;
        m_last = 1;
      end
    end else if (bus.mem_req_ready) begin
      m_owner = 0;
    end
  endtask

  // Inputs change at posedge+1, so values seen at negedge are what the
  // following posedge captures.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_compare();
      model_advance();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_req_valid   = 1'b0;
    bus.i_req_addr    = '0;
    bus.d_req_valid   = 1'b0;
    bus.d_req_wr      = 1'b0;
    bus.d_req_addr    = '0;
    bus.d_wr_data     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_req_data  = '0;
  endtask

  int order[4];
  int exp_order[4];

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    sample();
    chk("rst_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_owner", {30'd0, bus.arb_owner}, 32'd0);
    chk("rst_addr",  bus.mem_req_addr, 32'd0);
    chk("rst_wdata", bus.mem_wr_data, 32'd0);
    chk("rst_rdy",   {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
    step();
    rst = 1'b0;

    // T1: I-cache read, memory answers 3 cycles after grant
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0040;
    step();
    sample();
    chk("t1_owner", {30'd0, bus.arb_owner}, 32'd1);
    chk("t1_addr",  bus.mem_req_addr, 32'h0040);
    chk("t1_wr",    {31'd0, bus.mem_req_wr}, 32'd0);
    step(); step(); step();
    bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'hDEADBEEF;
    sample();
    chk("t1_i_rdy",  {31'd0, bus.i_req_ready}, 32'd1);
    chk("t1_i_data", bus.i_req_data, 32'hDEADBEEF);
    chk("t1_d_rdy",  {31'd0, bus.d_req_ready}, 32'd0);
    step();
    idle_inputs();
    sample();
    chk("t1_pulse", {31'd0, bus.i_req_ready}, 32'd0);
    chk("t1_idle",  {30'd0, bus.arb_owner}, 32'd0);

    // T2: D-cache write-back
    step();
    bus.d_req_valid = 1'b1; bus.d_req_wr = 1'b1;
    bus.d_req_addr = 32'h0100; bus.d_wr_data = 32'h12345678;
    step();
    sample();
    chk("t2_wr",    {31'd0, bus.mem_req_wr}, 32'd1);
    chk("t2_wdata", bus.mem_wr_data, 32'h12345678);
    chk("t2_owner", {30'd0, bus.arb_owner}, 32'd2);
    step();
    bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'h0BADF00D;
    sample();
    chk("t2_d_rdy", {31'd0, bus.d_req_ready}, 32'd1);
    chk("t2_i_rdy", {31'd0, bus.i_req_ready}, 32'd0);
    step();
    idle_inputs();
    sample();
    chk("t2_owner_back", {30'd0, bus.arb_owner}, 32'd0);
    chk("t2_pulse", {31'd0, bus.d_req_ready}, 32'd0);

    // T3: simultaneous held requests from a fresh reset
    step(); rst = 1'b1; step(); rst = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0400;
    bus.d_req_valid = 1'b1; bus.d_req_wr = 1'b0; bus.d_req_addr = 32'h0800;
`ifdef ARB_RR_EN
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 1;
`else
    exp_order[0] = 2; exp_order[1] = 2; exp_order[2] = 2; exp_order[3] = 2;
`endif
    for (int k = 0; k < 4; k++) begin
      int waited;
      waited = 0;
      sample();
      while (bus.arb_owner == 2'b00 && waited < 10) begin
        step(); sample(); waited++;
      end
      chk("t3_grant_timeout", waited, (waited < 10) ? waited : 0);
      order[k] = int'(bus.arb_owner);
      chk($sformatf("t3_order%0d", k), order[k], exp_order[k]);
      step();
      bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'h1000 + k;
      step();
      bus.mem_req_ready = 1'b0;
    end
    idle_inputs();
    step(); step();

    // T4: I-cache drops valid right after grant
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0080;
    step();
    bus.i_req_valid = 1'b0;
    sample();
    chk("t4_owner", {30'd0, bus.arb_owner}, 32'd1);
    step();
    sample();
    chk("t4_held", {31'd0, bus.mem_req_valid}, 32'd1);
    step();
    bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'h0000A5A5;
    sample();
    chk("t4_i_rdy",  {31'd0, bus.i_req_ready}, 32'd1);
    chk("t4_i_data", bus.i_req_data, 32'h0000A5A5);
    step();
    idle_inputs();
    sample();
    chk("t4_idle", {30'd0, bus.arb_owner}, 32'd0);

    // T5: reset while D grant waits, late memory ready
    step();
    bus.d_req_valid = 1'b1; bus.d_req_wr = 1'b0; bus.d_req_addr = 32'h0200;
    step();
    bus.d_req_valid = 1'b0;
    sample();
    chk("t5_owner", {30'd0, bus.arb_owner}, 32'd2);
    step();
    rst = 1'b1;
    sample();
    chk("t5_rst_rdy", {31'd0, bus.d_req_ready}, 32'd0);
    step();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'h00000055;
    sample();
    chk("t5_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("t5_owner0", {30'd0, bus.arb_owner}, 32'd0);
    chk("t5_d_rdy", {31'd0, bus.d_req_ready}, 32'd0);
    chk("t5_d_data", bus.d_req_data, 32'd0);
    chk("t5_addr",  bus.mem_req_addr, 32'd0);
    chk("t5_wr",    {31'd0, bus.mem_req_wr}, 32'd0);

    // T6: memory ready while IDLE
    step();
    bus.mem_req_ready = 1'b1; bus.mem_req_data = 32'hCAFEF00D;
    sample();
    chk("t6_rdy",  {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
    chk("t6_data", bus.i_req_data | bus.d_req_data, 32'd0);
    step();
    bus.mem_req_ready = 1'b0;
    sample();
    chk("t6_owner", {30'd0, bus.arb_owner}, 32'd0);
    chk("t6_valid", {31'd0, bus.mem_req_valid}, 32'd0);

    // Random phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      rst               = ($urandom_range(0, 99) == 0);
      bus.i_req_valid   = ($urandom_range(0, 9) < 5);
      bus.i_req_addr    = $urandom;
      bus.d_req_valid   = ($urandom_range(0, 9) < 5);
      bus.d_req_wr      = $urandom_range(0, 1);
      bus.d_req_addr    = $urandom;
      bus.d_wr_data     = $urandom;
      bus.mem_req_ready = ($urandom_range(0, 2) == 0);
      bus.mem_req_data  = $urandom;
    end
    step();
    idle_inputs();
    rst = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
